ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter: sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset. It is the transmit-direction counterpart of the byte receiver that feeds ps2_parser.
- Drives the open-collector PS/2 clock and data lines through output-enable pins: oe=1 pulls the line low, oe=0 releases it.
- Checks the device acknowledge.
- Reports completion or error to the command sequencer.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_line_filter.sv | 60 ++++++
 rtl/ps2_host_tx.sv | 199 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame size,
// common keyboard command bytes and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_REL
  } ps2_tx_state_t;

  // Host-driven bits after the start bit: 8 data, parity, stop.
  localparam int PS2_FRAME_BITS = 10;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

  // Parity bit that makes the total count of ones (data + parity) odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditioning for one raw PS/2 line: 2-FF synchronizer, a deglitch filter
// that needs FILTER_LEN consecutive equal samples before accepting a new
// level, and a one-cycle pulse on each accepted 1->0 transition.
// The line idles high, so everything resets to the released level.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic line_out,
  output logic fall
);

  localparam int SYNC_STAGES = 2;
  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   filt_reg;
  logic                   fall_reg;
  logic                   sync_level;

  assign sync_level = sync_reg[SYNC_STAGES-1];

  // Bring the asynchronous line into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], line_in};
    end
  end

  // Accept a new level only after it has persisted for FILTER_LEN samples;
  // any sample matching the current level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      filt_reg <= 1'b1;
      fall_reg <= 1'b0;
    end else begin
      fall_reg <= 1'b0;
      if (sync_level == filt_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        cnt_reg  <= '0;
        filt_reg <= sync_level;
        fall_reg <= filt_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign line_out = filt_reg;
  assign fall     = fall_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the bus, issues request-to-send,
// shifts out data/parity/stop on device clock falls, samples the device ACK
// and reports done or err (timeout) to the command sequencer.
// Optional macro PS2_TX_ACK_CHECK_EN: a NACK (data high at the ACK fall)
// ends the transfer with err instead of done.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       BIT_LAST = 4'(PS2_FRAME_BITS - 1);

  ps2_tx_state_t             state_reg, state_next;
  logic [PS2_FRAME_BITS-1:0] shift_reg, shift_next;
  logic [3:0]                bit_cnt_reg, bit_cnt_next;
  logic [INH_W-1:0]          inh_cnt_reg, inh_cnt_next;
  logic [TO_W-1:0]           to_cnt_reg, to_cnt_next;
  logic                      clk_oe_reg, clk_oe_next;
  logic                      data_oe_reg, data_oe_next;
  logic                      done_reg, done_next;
  logic                      err_reg, err_next;
`ifdef PS2_TX_ACK_CHECK_EN
  logic                      nack_reg, nack_next;
`endif

  logic clk_filt;
  logic clk_fall;
  logic data_filt;
  logic data_fall_unused;  // data edges are only needed by the receiver
  logic timeout_hit;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_in  (ps2_clk_in),
    .line_out (clk_filt),
    .fall     (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_in  (ps2_data_in),
    .line_out (data_filt),
    .fall     (data_fall_unused)
  );

  // The bus watchdog only runs while we wait on the device clock.
  assign timeout_hit = ((state_reg == SHIFT) || (state_reg == ACK) ||
                        (state_reg == WAIT_REL)) && (to_cnt_reg == TO_LAST);

  // State, counters and registered line drivers; reset releases both lines
  // immediately without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '1;
      bit_cnt_reg <= '0;
      inh_cnt_reg <= '0;
      to_cnt_reg  <= '0;
      clk_oe_reg  <= 1'b0;
      data_oe_reg <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
      nack_reg    <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      inh_cnt_reg <= inh_cnt_next;
      to_cnt_reg  <= to_cnt_next;
      clk_oe_reg  <= clk_oe_next;
      data_oe_reg <= data_oe_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
`ifdef PS2_TX_ACK_CHECK_EN
      nack_reg    <= nack_next;
`endif
    end
  end

  // Next-state and line-drive decisions; timeout overrides everything else.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    inh_cnt_next = inh_cnt_reg;
    to_cnt_next  = to_cnt_reg;
    clk_oe_next  = clk_oe_reg;
    data_oe_next = data_oe_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
    nack_next    = nack_reg;
`endif

    case (state_reg)
      IDLE: begin
        clk_oe_next  = 1'b0;
        data_oe_next = 1'b0;
        if (tx_valid) begin
          shift_next   = {1'b1, odd_parity(tx_byte), tx_byte};
          bit_cnt_next = '0;
          inh_cnt_next = '0;
          clk_oe_next  = 1'b1;
          state_next   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt_reg == INH_LAST) begin
          clk_oe_next  = 1'b0;
          data_oe_next = 1'b1;  // start bit
          to_cnt_next  = '0;
          state_next   = REQ;
        end else begin
          inh_cnt_next = inh_cnt_reg + 1'b1;
        end
      end
      REQ: begin
        to_cnt_next = '0;
        state_next  = SHIFT;
      end
      SHIFT: begin
        to_cnt_next = to_cnt_reg + 1'b1;
        if (clk_fall) begin
          data_oe_next = ~shift_reg[bit_cnt_reg];
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == BIT_LAST) begin
            state_next = ACK;
          end
        end
      end
      ACK: begin
        to_cnt_next = to_cnt_reg + 1'b1;
        if (clk_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
          nack_next = data_filt;
`endif
          state_next = WAIT_REL;
        end
      end
      WAIT_REL: begin
        to_cnt_next = to_cnt_reg + 1'b1;
        if (clk_filt && data_filt) begin
`ifdef PS2_TX_ACK_CHECK_EN
          err_next  = nack_reg;
          done_next = ~nack_reg;
`else
          done_next = 1'b1;
`endif
          state_next = IDLE;
        end
      end
      default: begin
        clk_oe_next  = 1'b0;
        data_oe_next = 1'b0;
        state_next   = IDLE;
      end
    endcase

    if (timeout_hit) begin
      clk_oe_next  = 1'b0;
      data_oe_next = 1'b0;
      done_next    = 1'b0;
      err_next     = 1'b1;
      state_next   = IDLE;
    end
  end

  assign tx_ready    = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign err         = err_reg;
  assign ps2_clk_oe  = clk_oe_reg;
  assign ps2_data_oe = data_oe_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-collector PS/2 device
// model. Parameters are scaled down so the run stays short.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 40;
  localparam int TO   = 4000;
  localparam int FL   = 4;
  localparam int HALF = 60;
`ifdef PS2_TX_ACK_CHECK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, err;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_pull = 1'b0;
  logic       dev_data_pull = 1'b0;

  // Wired-AND bus: either side pulling makes the line low.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_pull);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_pull);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .err(err),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0, err_cnt = 0;
  int cyc = 0, rel_cyc = 0, err_cyc = 0;
  int inh_run = 0, last_inhibit = 0;
  logic prev_clk_oe = 1'b0;

  // Passive monitor: pulse counts, inhibit length and event timestamps.
  always @(negedge clk) begin
    cyc++;
    if (done) done_cnt++;
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (ps2_clk_oe) inh_run++;
    else if (prev_clk_oe) begin
      last_inhibit = inh_run;
      rel_cyc = cyc;
      inh_run = 0;
    end
    prev_clk_oe = ps2_clk_oe;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame from the protocol rules: data LSB first, then a parity
  // bit making the number of ones odd, then a released stop bit.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b};
  endfunction

  task automatic wait_oe(input logic level, input int limit, input string tag);
    int n = 0;
    while (ps2_clk_oe !== level && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, (n < limit), 1);
  endtask

  // Device side of one host-to-device frame: 11 clock pulses, reading the
  // data line just before each rising edge, optional ACK on the 11th.
  task automatic run_device(input bit do_ack, output logic [9:0] seen, output logic start_bit);
    seen = '0;
    wait_oe(1'b1, 10, "inhibit_start");
    wait_oe(1'b0, INH + 10, "inhibit_end");
    repeat (20) @(negedge clk);
    start_bit = ps2_data_in;
    for (int i = 0; i < 11; i++) begin
      if (i == 10 && do_ack) dev_data_pull = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_pull = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i < 10) seen[i] = ps2_data_in;
      dev_clk_pull = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    dev_data_pull = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int e0, input int limit, input string tag);
    int n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, (n < limit), 1);
  endtask

  task automatic do_transfer(input logic [7:0] b, input bit ack, input bit exp_done, input bit exp_err);
    int d0, e0;
    logic [9:0] seen;
    logic start_bit;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    check("ready_before", tx_ready, 1);
    tx_byte  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_byte  = ~b;  // must not affect the frame in flight
    check("busy_after_accept", busy, 1);
    check("ready_after_accept", tx_ready, 0);
    run_device(ack, seen, start_bit);
    wait_end(d0, e0, 200, "end_of_transfer");
    repeat (5) @(negedge clk);
    check("inhibit_len", last_inhibit, INH);
    check("start_bit", start_bit, 0);
    check("frame_bits", seen, exp_frame(b));
    check("done_pulses", done_cnt - d0, exp_done);
    check("err_pulses", err_cnt - e0, exp_err);
    check("busy_end", busy, 0);
    check("oe_released", {ps2_clk_oe, ps2_data_oe}, 0);
    $display("tx %02h ack=%0d frame=%b done=%0d err=%0d", b, ack, seen,
             done_cnt - d0, err_cnt - e0);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         exp_done;
    bit         exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [9:0] seen;
    logic       sb;
    int         d0, e0;

    vecs[0] = '{PS2_CMD_SET_LED, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h07,           1'b1, 1'b1, 1'b0};
    vecs[2] = '{PS2_CMD_RESET,   1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h00,           1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'hA5,           1'b0, !ACK_CHK, ACK_CHK};
    vecs[5] = '{8'h3C,           1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_ready", tx_ready, 1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Table-driven transfers
    for (int i = 0; i < 6; i++)
      do_transfer(vecs[i].data, vecs[i].ack, vecs[i].exp_done, vecs[i].exp_err);

    // Randomized transfers against the reference model
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      bit a;
      b = 8'($urandom_range(0, 255));
      a = ($urandom_range(0, 3) != 0);
      do_transfer(b, a, a || !ACK_CHK, !a && ACK_CHK);
    end

    // Timeout: device never clocks
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    tx_byte = 8'h5A;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_end(d0, e0, INH + TO + 200, "timeout_seen");
    repeat (3) @(negedge clk);
    check("timeout_latency", err_cyc - rel_cyc, TO + 1);
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_no_done", done_cnt - d0, 0);
    check("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("timeout_ready", tx_ready, 1);
    $display("tx 5a no device clock err after %0d cycles", err_cyc - rel_cyc);

    // tx_valid held with a new byte while busy: not queued, taken after done
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    tx_byte = PS2_CMD_RESET;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_byte = 8'h55;
    run_device(1'b1, seen, sb);
    check("busy_hold_frame", seen, exp_frame(PS2_CMD_RESET));
    wait_end(d0, e0, 200, "busy_hold_end");
    @(negedge clk);
    check("busy_hold_done", done_cnt - d0, 1);
    check("second_accept", busy, 1);
    tx_valid = 1'b0;
    $display("tx ff with 55 held frame=%b", seen);
    d0 = done_cnt;
    run_device(1'b1, seen, sb);
    check("second_frame", seen, exp_frame(8'h55));
    wait_end(d0, e0, 200, "second_end");
    repeat (5) @(negedge clk);
    check("second_done", done_cnt - d0, 1);
    $display("tx 55 after done frame=%b", seen);

    // Reset during the inhibit releases the clock line at once
    @(negedge clk);
    tx_byte = 8'h11;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("inhibit_active", ps2_clk_oe, 1);
    #1 rst_n = 1'b0;
    #1 check("async_rst_clk_oe", ps2_clk_oe, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Reset during bit 4: lines released before the next clock edge
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    tx_byte = 8'h0F;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_oe(1'b0, INH + 10, "partial_release");
    repeat (20) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      repeat (HALF) @(negedge clk);
      dev_clk_pull = 1'b1;
      if (i < 4) begin
        repeat (HALF) @(negedge clk);
        dev_clk_pull = 1'b0;
      end
    end
    repeat (HALF / 2) @(negedge clk);
    check("bit4_driven", ps2_data_oe, 1);
    #1 rst_n = 1'b0;
    #1 check("async_rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    dev_clk_pull = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_no_err", err_cnt - e0, 0);
    check("rst_ready_after", tx_ready, 1);
    $display("tx 0f reset during bit 4, lines released");
    do_transfer(8'hF4, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
